// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: opcodes, bus size codes,
// exception codes and the pending-transaction record.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LBU = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LHU = 4'd3,
    LSU_LW  = 4'd4,
    LSU_SB  = 4'd5,
    LSU_SH  = 4'd6,
    LSU_SW  = 4'd7,
    LSU_LWL = 4'd8,
    LSU_LWR = 4'd9,
    LSU_SWL = 4'd10,
    LSU_SWR = 4'd11
  } lsu_op_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int LSU_REG_W = 5;

  typedef struct packed {
    lsu_op_t              op;
    logic [1:0]           addr_lo;
    logic [LSU_REG_W-1:0] wd;
    logic [31:0]          pc;
    logic                 wr;
`ifdef LSU_UNALIGNED_LR_EN
    // The old rt value is only needed to merge LWL/LWR results.
    logic [31:0]          rt;
`endif
    logic                 kill;
  } lsu_entry_t;

  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave).
// Handshake: an address is transferred in any cycle with data_req && data_addr_ok; each
// data_data_ok cycle completes the oldest accepted transaction (data_rdata valid with it).
// With LSU_UNALIGNED_LR_EN defined, data_wstrb carries the byte enables of the request.
interface mem_lsu_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
`ifdef LSU_UNALIGNED_LR_EN
  logic [3:0]  data_wstrb;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_rdata, data_addr_ok, data_data_ok
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_rdata, data_addr_ok, data_data_ok
  );
`else
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
`endif
endinterface

// File: rtl/mem_lsu_pending_fifo.sv
// Circular buffer of in-flight bus transactions, oldest at head. kill_all marks every
// live entry (and one written the same cycle) so its response is swallowed on pop.
module lsu_pending_fifo
  import mem_lsu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  lsu_entry_t    entry_i,
  input  logic          pop_i,
  input  logic          kill_all_i,
  output logic [CW-1:0] count_o,
  output lsu_entry_t    head_o
);

  lsu_entry_t       mem_q   [DEPTH];
  lsu_entry_t       mem_d   [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;

    if (kill_all_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) mem_d[i].kill = 1'b1;
      end
    end
    if (pop_i) begin
      valid_d[rd_q] = 1'b0;
      rd_d          = next_ptr(rd_q);
    end
    if (push_i) begin
      mem_d[wr_q]      = entry_i;
      mem_d[wr_q].kill = kill_all_i;
      valid_d[wr_q]    = 1'b1;
      wr_d             = next_ptr(wr_q);
    end

    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues on the data bus, tracks up to DEPTH transactions,
// returns in-order responses. Optional LWL/LWR/SWL/SWR behind LSU_UNALIGNED_LR_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int PADDR_BITS = 29,
  parameter int REG_ADDR_W = LSU_REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [REG_ADDR_W-1:0] req_wd,
  input  logic [31:0]           req_pc,
  output logic                  req_ready,
  output logic                  lsu_stall,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_badvaddr,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [REG_ADDR_W-1:0] resp_wd,
  output logic [31:0]           resp_wdata,
  output logic [31:0]           resp_pc,
  output logic                  pending,
  mem_lsu_if.master             bus
);

  localparam int CW = $clog2(DEPTH + 1);

  lsu_op_t       op;
  logic          op_ok, is_store, is_lr, misaligned;
  logic [1:0]    size;
  logic [1:0]    lo;
  logic [31:0]   st_data, addr_phys, addr_bus;
  logic          active, issue, drop, push, pop;
  logic [CW-1:0] count;
  lsu_entry_t    push_entry, head;
  logic [31:0]   load_data;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
`ifdef LSU_UNALIGNED_LR_EN
  logic [3:0]    wstrb;
`endif

  assign op = lsu_op_t'(req_op);
  assign lo = req_addr[1:0];

  always_comb begin
    op_ok      = 1'b1;
    is_store   = 1'b0;
    is_lr      = 1'b0;
    misaligned = 1'b0;
    size       = SZ_W;
    st_data    = '0;
`ifdef LSU_UNALIGNED_LR_EN
    wstrb      = 4'b0000;
`endif
    case (op)
      LSU_LB, LSU_LBU: size = SZ_B;
      LSU_LH, LSU_LHU: begin size = SZ_H; misaligned = lo[0]; end
      LSU_LW:          misaligned = |lo;
      LSU_SB: begin
        size = SZ_B; is_store = 1'b1; st_data = {4{req_wdata[7:0]}};
`ifdef LSU_UNALIGNED_LR_EN
        wstrb = 4'b0001 << lo;
`endif
      end
      LSU_SH: begin
        size = SZ_H; is_store = 1'b1; misaligned = lo[0]; st_data = {2{req_wdata[15:0]}};
`ifdef LSU_UNALIGNED_LR_EN
        wstrb = lo[1] ? 4'b1100 : 4'b0011;
`endif
      end
      LSU_SW: begin
        is_store = 1'b1; misaligned = |lo; st_data = req_wdata;
`ifdef LSU_UNALIGNED_LR_EN
        wstrb = 4'b1111;
`endif
      end
`ifdef LSU_UNALIGNED_LR_EN
      LSU_LWL, LSU_LWR: is_lr = 1'b1;
      // SWL writes bytes 0..lo from the top of rt; SWR writes bytes lo..3 from the bottom.
      LSU_SWL: begin
        is_lr = 1'b1; is_store = 1'b1;
        st_data = req_wdata >> lane_shift(2'd3 - lo);
        wstrb   = 4'b1111 >> (2'd3 - lo);
      end
      LSU_SWR: begin
        is_lr = 1'b1; is_store = 1'b1;
        st_data = req_wdata << lane_shift(lo);
        wstrb   = 4'b1111 << lo;
      end
`endif
      default: op_ok = 1'b0;
    endcase
  end

  assign active    = req_valid && !rst;
  assign issue     = active && op_ok && !misaligned && !flush && (count < CW'(DEPTH));
  assign exc_valid = active && op_ok && misaligned && !flush;
  assign drop      = active && !op_ok;
  assign push      = issue && bus.data_addr_ok;
  assign pop       = bus.data_data_ok && (count != '0) && !rst;
  assign req_ready = push || exc_valid || drop;
  assign lsu_stall = active && !req_ready;

  assign exc_code     = exc_valid ? (is_store ? EXC_ADES : EXC_ADEL) : 5'd0;
  assign exc_badvaddr = exc_valid ? req_addr : 32'd0;

  assign addr_phys = 32'(req_addr[PADDR_BITS-1:0]);
  assign addr_bus  = is_lr ? {addr_phys[31:2], 2'b00} : addr_phys;

  assign bus.data_req   = issue;
  assign bus.data_wr    = issue && is_store;
  assign bus.data_size  = issue ? size : 2'd0;
  assign bus.data_addr  = issue ? addr_bus : 32'd0;
  assign bus.data_wdata = issue ? st_data : 32'd0;
`ifdef LSU_UNALIGNED_LR_EN
  assign bus.data_wstrb = issue ? wstrb : 4'b0000;
`endif

  always_comb begin
    push_entry         = '0;
    push_entry.op      = op;
    push_entry.addr_lo = lo;
    push_entry.wd      = LSU_REG_W'(req_wd);
    push_entry.pc      = req_pc;
    push_entry.wr      = is_store;
`ifdef LSU_UNALIGNED_LR_EN
    push_entry.rt      = req_wdata;
`endif
  end

  lsu_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .entry_i   (push_entry),
    .pop_i     (pop),
    .kill_all_i(flush && !rst),
    .count_o   (count),
    .head_o    (head)
  );

  // Extraction is combinational from data_rdata so the response leaves in the data_ok cycle.
  always_comb begin
    lane_b    = 8'(bus.data_rdata >> lane_shift(head.addr_lo));
    lane_h    = head.addr_lo[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    load_data = '0;
    case (head.op)
      LSU_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      LSU_LBU: load_data = {24'd0, lane_b};
      LSU_LH:  load_data = {{16{lane_h[15]}}, lane_h};
      LSU_LHU: load_data = {16'd0, lane_h};
      LSU_LW:  load_data = bus.data_rdata;
`ifdef LSU_UNALIGNED_LR_EN
      LSU_LWL: load_data = (bus.data_rdata << lane_shift(2'd3 - head.addr_lo)) |
                           (head.rt & ~(32'hFFFF_FFFF << lane_shift(2'd3 - head.addr_lo)));
      LSU_LWR: load_data = (bus.data_rdata >> lane_shift(head.addr_lo)) |
                           (head.rt & ~(32'hFFFF_FFFF >> lane_shift(head.addr_lo)));
`endif
      default: load_data = '0;
    endcase
  end

  assign resp_valid = pop && !head.kill;
  assign resp_we    = resp_valid && !head.wr;
  assign resp_wd    = resp_valid ? REG_ADDR_W'(head.wd) : '0;
  assign resp_wdata = resp_we ? load_data : 32'd0;
  assign resp_pc    = resp_valid ? head.pc : 32'd0;
  assign pending    = (count != '0) && !rst;

  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (rst)
    !(bus.data_data_ok && (count == '0)));

endmodule
